axi4lite_regbus_bridge: RTL and testbench
=========================================

AXI4LITE_REGBUS_BRIDGE -- requirements
Module: axi4lite_regbus_bridge

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- AXI_ADDR_WIDTH, 32, AXI address width
- AXI_DATA_WIDTH, 32, data width; only 32 supported
- ADDR_LSB, 2, byte-to-word shift
- REG_ADDR_WIDTH, 8, register-bus word-address width
- NUM_REGS, 256, implemented words; range 1..2^REG_ADDR_WIDTH
- RD_LATENCY, 2, cycles from read strobe to read_data sample; range 1..15
REQ-002 SHALL have ports (name, direction, width, meaning):
- aclk, in, 1, sole clock; all logic on rising edge
- aresetn, in, 1, reset, asynchronous, active-low
- s_axi_aw{addr,valid,ready}, in/in/out, AXI_ADDR_WIDTH/1/1, AXI4-Lite write address
- s_axi_w{data,strb,valid,ready}, in/in/in/out, 32/4/1/1, write data
- s_axi_b{resp,valid,ready}, out/out/in, 2/1/1, write response
- s_axi_ar{addr,valid,ready}, in/in/out, AXI_ADDR_WIDTH/1/1, read address
- s_axi_r{data,resp,valid,ready}, out/out/out/in, 32/2/1/1, read data
- chip_select, write, read, out, 1 each, register-bus strobes
- address, out, REG_ADDR_WIDTH, word address = axaddr[ADDR_LSB+REG_ADDR_WIDTH-1:ADDR_LSB]
- write_data, out, 32; read_data, in, 32
REQ-003 All outputs SHALL be registered.

Function
REQ-004 AW, W, AR SHALL each have a one-entry holding register with full flag; xREADY = !full, registered.
REQ-005 AW and W SHALL be accepted independently, in either order or simultaneously.
REQ-006 AW/W full flags SHALL clear at the B handshake edge; AR full flag at the R handshake edge; READY reasserts the following cycle.
REQ-007 Bus FSM states: IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT, RESP.
REQ-008 IDLE: write pending = AW full and W full; read pending = AR full; if both pending, grant the type not granted last; first grant after reset is read.
REQ-009 WR_ISSUE/RD_ISSUE SHALL drive chip_select=1 plus write=1 or read=1 for exactly one cycle, with address and write_data valid.
REQ-010 Write: bvalid=1 at the edge after the strobe cycle, i.e. 2 edges after both AW and W are held.
REQ-011 Read: RD_WAIT SHALL count RD_LATENCY-1 cycles; read_data sampled into s_axi_rdata at the edge RD_LATENCY cycles after the strobe edge, with rvalid=1 at that edge.
REQ-012 Error: word address >= NUM_REGS, or write with wstrb != 4'hF -> no strobe (chip_select/read/write stay 0); identical timing; resp=2'b10 (SLVERR); error rdata=0.
REQ-013 OKAY responses SHALL have resp=2'b00.
REQ-014 bvalid/rvalid SHALL hold with bresp/rresp/rdata stable until READY; FSM returns to IDLE at the handshake edge.
REQ-015 At most one downstream access in flight; no strobe while bvalid or rvalid is high.

Reset
REQ-016 aresetn low SHALL immediately clear: all READY/VALID, strobes, resp, rdata, address, write_data, full flags; FSM to IDLE; arbiter to read-first.
REQ-017 Reset mid-transaction SHALL abort it with no response; READYs are 1 the first cycle after release.

Verification
REQ-018 AR addr 0x10 at edge 0, read_data=0xA5A5_0004, rready=1 -> read=1 and address=0x04 in cycle 1; rvalid=1, rdata=0xA5A5_0004, rresp=0 at edge 3.
REQ-019 W (data 0x1234, strb 0xF) 2 cycles before AW addr 0x08 -> single write pulse, address=0x02, write_data=0x1234; bvalid 2 edges after AW accept.
REQ-020 AR and AW/W all pending in the same IDLE cycle after reset -> read strobe first, write strobe second; repeat -> write first.
REQ-021 NUM_REGS=16: read addr 0x40 -> no strobe, rresp=2'b10, rdata=0; write with strb 0x3 -> no strobe, bresp=2'b10.
REQ-022 rready held low 5 cycles -> rvalid/rdata stable, arready=0 throughout; accepted the cycle after handshake.
REQ-023 aresetn pulsed low during RD_WAIT -> rvalid stays 0, strobes 0, arready/awready/wready=1 the first cycle after release.

Source files
------------

// File: rtl/axi4lite_regbus_bridge.sv
// AXI4-Lite slave to simple register-bus bridge. AW, W and AR each have a
// one-entry holding register. At most one register access is in flight.
module axi4lite_regbus_bridge #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned ADDR_LSB       = 2,
    parameter int unsigned REG_ADDR_WIDTH = 8,
    parameter int unsigned NUM_REGS       = 256,
    parameter int unsigned RD_LATENCY     = 2
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                        s_axi_awvalid,
    output logic                        s_axi_awready,
    input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                        s_axi_wvalid,
    output logic                        s_axi_wready,
    output logic [1:0]                  s_axi_bresp,
    output logic                        s_axi_bvalid,
    input  logic                        s_axi_bready,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                        s_axi_arvalid,
    output logic                        s_axi_arready,
    output logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                  s_axi_rresp,
    output logic                        s_axi_rvalid,
    input  logic                        s_axi_rready,
    output logic                        chip_select,
    output logic                        write,
    output logic                        read,
    output logic [REG_ADDR_WIDTH-1:0]   address,
    output logic [AXI_DATA_WIDTH-1:0]   write_data,
    input  logic [AXI_DATA_WIDTH-1:0]   read_data
);
    localparam int unsigned STRB_WIDTH   = AXI_DATA_WIDTH / 8;
    localparam int unsigned CNT_WIDTH    = 4;
    localparam int unsigned CMP_WIDTH    = REG_ADDR_WIDTH + 1;
    localparam int unsigned RD_WAIT_INIT = (RD_LATENCY > 1) ? RD_LATENCY - 2 : 0;
    localparam logic [1:0]  RESP_OKAY    = 2'b00;
    localparam logic [1:0]  RESP_SLVERR  = 2'b10;

    typedef enum logic [2:0] {IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT, RESP} state_t;

    state_t                      state, state_d;
    logic                        aw_full, aw_full_d, w_full, w_full_d, ar_full, ar_full_d;
    logic [REG_ADDR_WIDTH-1:0]   aw_addr, aw_addr_d, ar_addr, ar_addr_d;
    logic [AXI_DATA_WIDTH-1:0]   w_data, w_data_d;
    logic [STRB_WIDTH-1:0]       w_strb, w_strb_d;
    logic                        prefer_wr, prefer_wr_d;
    logic                        err, err_d;
    logic [CNT_WIDTH-1:0]        cnt, cnt_d;
    logic                        awready_d, wready_d, arready_d;
    logic                        bvalid_d, rvalid_d, cs_d, write_d, read_d;
    logic [1:0]                  bresp_d, rresp_d;
    logic [AXI_DATA_WIDTH-1:0]   rdata_d, write_data_d;
    logic [REG_ADDR_WIDTH-1:0]   address_d;
    logic                        wr_pend, rd_pend, wr_err, rd_err;
    logic                        unused_addr_bits;

    // Only the word-address slice of the AXI addresses is decoded.
    assign unused_addr_bits = ^{s_axi_awaddr, s_axi_araddr};

    always_comb begin
        state_d      = state;
        aw_full_d    = aw_full;
        aw_addr_d    = aw_addr;
        w_full_d     = w_full;
        w_data_d     = w_data;
        w_strb_d     = w_strb;
        ar_full_d    = ar_full;
        ar_addr_d    = ar_addr;
        prefer_wr_d  = prefer_wr;
        err_d        = err;
        cnt_d        = cnt;
        bvalid_d     = s_axi_bvalid;
        bresp_d      = s_axi_bresp;
        rvalid_d     = s_axi_rvalid;
        rresp_d      = s_axi_rresp;
        rdata_d      = s_axi_rdata;
        address_d    = address;
        write_data_d = write_data;
        cs_d         = 1'b0;
        write_d      = 1'b0;
        read_d       = 1'b0;

        wr_pend = aw_full && w_full;
        rd_pend = ar_full;
        wr_err  = ({1'b0, aw_addr} >= CMP_WIDTH'(NUM_REGS)) || !(&w_strb);
        rd_err  = ({1'b0, ar_addr} >= CMP_WIDTH'(NUM_REGS));

        if (s_axi_awvalid && s_axi_awready) begin
            aw_full_d = 1'b1;
            aw_addr_d = s_axi_awaddr[ADDR_LSB +: REG_ADDR_WIDTH];
        end
        if (s_axi_wvalid && s_axi_wready) begin
            w_full_d = 1'b1;
            w_data_d = s_axi_wdata;
            w_strb_d = s_axi_wstrb;
        end
        if (s_axi_arvalid && s_axi_arready) begin
            ar_full_d = 1'b1;
            ar_addr_d = s_axi_araddr[ADDR_LSB +: REG_ADDR_WIDTH];
        end

        case (state)
            IDLE: begin
                // Priority only flips when both types contend.
                if (wr_pend && (!rd_pend || prefer_wr)) begin
                    state_d      = WR_ISSUE;
                    err_d        = wr_err;
                    address_d    = aw_addr;
                    write_data_d = w_data;
                    cs_d         = !wr_err;
                    write_d      = !wr_err;
                    if (rd_pend) prefer_wr_d = 1'b0;
                end else if (rd_pend) begin
                    state_d   = RD_ISSUE;
                    err_d     = rd_err;
                    address_d = ar_addr;
                    cs_d      = !rd_err;
                    read_d    = !rd_err;
                    if (wr_pend) prefer_wr_d = 1'b1;
                end
            end
            WR_ISSUE: begin
                state_d  = RESP;
                bvalid_d = 1'b1;
                bresp_d  = err ? RESP_SLVERR : RESP_OKAY;
            end
            RD_ISSUE: begin
                if (RD_LATENCY <= 1) begin
                    state_d  = RESP;
                    rvalid_d = 1'b1;
                    rresp_d  = err ? RESP_SLVERR : RESP_OKAY;
                    rdata_d  = err ? '0 : read_data;
                end else begin
                    state_d = RD_WAIT;
                    cnt_d   = CNT_WIDTH'(RD_WAIT_INIT);
                end
            end
            RD_WAIT: begin
                if (cnt == '0) begin
                    state_d  = RESP;
                    rvalid_d = 1'b1;
                    rresp_d  = err ? RESP_SLVERR : RESP_OKAY;
                    rdata_d  = err ? '0 : read_data;
                end else begin
                    cnt_d = cnt - CNT_WIDTH'(1);
                end
            end
            RESP: begin
                if (s_axi_bvalid && s_axi_bready) begin
                    state_d   = IDLE;
                    bvalid_d  = 1'b0;
                    aw_full_d = 1'b0;
                    w_full_d  = 1'b0;
                end else if (s_axi_rvalid && s_axi_rready) begin
                    state_d   = IDLE;
                    rvalid_d  = 1'b0;
                    ar_full_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        awready_d = !aw_full_d;
        wready_d  = !w_full_d;
        arready_d = !ar_full_d;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= IDLE;
            aw_full       <= 1'b0;
            aw_addr       <= '0;
            w_full        <= 1'b0;
            w_data        <= '0;
            w_strb        <= '0;
            ar_full       <= 1'b0;
            ar_addr       <= '0;
            prefer_wr     <= 1'b0;
            err           <= 1'b0;
            cnt           <= '0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_arready <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= 2'b00;
            s_axi_rvalid  <= 1'b0;
            s_axi_rresp   <= 2'b00;
            s_axi_rdata   <= '0;
            chip_select   <= 1'b0;
            write         <= 1'b0;
            read          <= 1'b0;
            address       <= '0;
            write_data    <= '0;
        end else begin
            state         <= state_d;
            aw_full       <= aw_full_d;
            aw_addr       <= aw_addr_d;
            w_full        <= w_full_d;
            w_data        <= w_data_d;
            w_strb        <= w_strb_d;
            ar_full       <= ar_full_d;
            ar_addr       <= ar_addr_d;
            prefer_wr     <= prefer_wr_d;
            err           <= err_d;
            cnt           <= cnt_d;
            s_axi_awready <= awready_d;
            s_axi_wready  <= wready_d;
            s_axi_arready <= arready_d;
            s_axi_bvalid  <= bvalid_d;
            s_axi_bresp   <= bresp_d;
            s_axi_rvalid  <= rvalid_d;
            s_axi_rresp   <= rresp_d;
            s_axi_rdata   <= rdata_d;
            chip_select   <= cs_d;
            write         <= write_d;
            read          <= read_d;
            address       <= address_d;
            write_data    <= write_data_d;
        end
    end
endmodule

// File: tb/tb_axi4lite_regbus_bridge.sv
// Directed bench for axi4lite_regbus_bridge: vector table of single
// transactions plus hand sequences for ordering, back-pressure and reset.
module tb_axi4lite_regbus_bridge;
    localparam logic [7:0] K_RD = 8'h52;
    localparam logic [7:0] K_WR = 8'h57;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] s_axi_awaddr, s_axi_wdata, s_axi_araddr, s_axi_rdata;
    logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
    logic [3:0]  s_axi_wstrb;
    logic [1:0]  s_axi_bresp, s_axi_rresp;
    logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
    logic        s_axi_rvalid, s_axi_rready;
    logic        chip_select, write, read;
    logic [7:0]  address;
    logic [31:0] write_data, read_data;

    always #5 aclk = ~aclk;

    axi4lite_regbus_bridge #(
        .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .ADDR_LSB(2),
        .REG_ADDR_WIDTH(8), .NUM_REGS(16), .RD_LATENCY(2)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
        .s_axi_rready(s_axi_rready),
        .chip_select(chip_select), .write(write), .read(read),
        .address(address), .write_data(write_data), .read_data(read_data)
    );

    typedef struct {
        logic        is_wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] rd_val;
        logic        exp_strobe;
        logic [7:0]  exp_addr;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    int         n_pass = 0;
    int         n_total = 0;
    int         overlap_cnt = 0;
    logic [7:0] strobe_log[$];

    // Log every register-bus strobe in order; flag any issued during a response.
    always @(negedge aclk) begin
        if (chip_select || read || write) begin
            strobe_log.push_back((read && !write) ? K_RD : ((write && !read) ? K_WR : 8'h3F));
            if (s_axi_bvalid || s_axi_rvalid) overlap_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic do_reset();
        @(negedge aclk);
        aresetn = 1'b0;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
    endtask

    // Called just after the accepting edge; i counts edges since acceptance.
    task automatic wait_resp(input logic is_wr, output int strobe_at, output int resp_at,
                             output logic [7:0] st_addr, output logic [31:0] st_wd,
                             output logic [1:0] resp, output logic [31:0] rdat);
        strobe_at = -1; resp_at = -1; st_addr = 8'h0; st_wd = 32'h0;
        resp = 2'b11; rdat = 32'hFFFF_FFFF;
        for (int i = 0; i < 20 && resp_at < 0; i++) begin
            @(negedge aclk);
            if (i == 0) begin
                s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
            end
            if (chip_select && strobe_at < 0) begin
                strobe_at = i; st_addr = address; st_wd = write_data;
            end
            if (is_wr ? s_axi_bvalid : s_axi_rvalid) begin
                resp_at = i;
                resp = is_wr ? s_axi_bresp : s_axi_rresp;
                rdat = s_axi_rdata;
            end
        end
    endtask

    task automatic run_txn(input vec_t v, input int idx);
        int          start, strobe_at, resp_at;
        logic [7:0]  st_addr;
        logic [31:0] st_wd, rdat;
        logic [1:0]  resp;
        start = strobe_log.size();
        read_data = v.rd_val;
        @(negedge aclk);
        check($sformatf("v%0d_ready", idx), 32'(v.is_wr ? (s_axi_awready && s_axi_wready) : s_axi_arready), 32'd1);
        if (v.is_wr) begin
            s_axi_awvalid = 1'b1; s_axi_awaddr = v.addr;
            s_axi_wvalid = 1'b1; s_axi_wdata = v.wdata; s_axi_wstrb = v.strb;
        end else begin
            s_axi_arvalid = 1'b1; s_axi_araddr = v.addr;
        end
        @(posedge aclk);
        wait_resp(v.is_wr, strobe_at, resp_at, st_addr, st_wd, resp, rdat);
        @(negedge aclk);
        check($sformatf("v%0d_nstrobe", idx), 32'(strobe_log.size() - start), 32'(v.exp_strobe));
        if (v.exp_strobe && strobe_log.size() > start) begin
            check($sformatf("v%0d_kind", idx), 32'(strobe_log[start]), 32'(v.is_wr ? K_WR : K_RD));
            check($sformatf("v%0d_strobe_at", idx), 32'(strobe_at), 32'd1);
            check($sformatf("v%0d_addr", idx), 32'(st_addr), 32'(v.exp_addr));
            if (v.is_wr) check($sformatf("v%0d_wdata", idx), st_wd, v.wdata);
        end
        check($sformatf("v%0d_resp_at", idx), 32'(resp_at), v.is_wr ? 32'd2 : 32'd3);
        check($sformatf("v%0d_resp", idx), 32'(resp), 32'(v.exp_resp));
        if (!v.is_wr) check($sformatf("v%0d_rdata", idx), rdat, v.exp_rdata);
        check($sformatf("v%0d_valid_drop", idx), 32'(s_axi_bvalid || s_axi_rvalid), 32'd0);
    endtask

    initial begin
        vec_t        vecs[9];
        int          start, strobe_at, resp_at, seen;
        logic [7:0]  st_addr;
        logic [31:0] st_wd, rdat;
        logic [1:0]  resp;

        vecs[0] = '{1'b0, 32'h10,  32'h0,         4'h0, 32'hA5A5_0004, 1'b1, 8'h04, 2'b00, 32'hA5A5_0004};
        vecs[1] = '{1'b0, 32'h3C,  32'h0,         4'h0, 32'hDEAD_BEEF, 1'b1, 8'h0F, 2'b00, 32'hDEAD_BEEF};
        vecs[2] = '{1'b0, 32'h40,  32'h0,         4'h0, 32'h1234_5678, 1'b0, 8'h00, 2'b10, 32'h0};
        vecs[3] = '{1'b0, 32'hFFC, 32'h0,         4'h0, 32'h1234_5678, 1'b0, 8'h00, 2'b10, 32'h0};
        vecs[4] = '{1'b1, 32'h08,  32'h0000_1234, 4'hF, 32'h0,         1'b1, 8'h02, 2'b00, 32'h0};
        vecs[5] = '{1'b1, 32'h04,  32'h0000_5555, 4'h3, 32'h0,         1'b0, 8'h00, 2'b10, 32'h0};
        vecs[6] = '{1'b1, 32'h44,  32'h0000_6666, 4'hF, 32'h0,         1'b0, 8'h00, 2'b10, 32'h0};
        vecs[7] = '{1'b1, 32'h3C,  32'hCAFE_F00D, 4'hF, 32'h0,         1'b1, 8'h0F, 2'b00, 32'h0};
        vecs[8] = '{1'b0, 32'h400, 32'h0,         4'h0, 32'h0000_0055, 1'b1, 8'h00, 2'b00, 32'h0000_0055};

        aresetn = 1'b1;
        s_axi_awaddr = 32'h0; s_axi_awvalid = 1'b0; s_axi_wdata = 32'h0; s_axi_wstrb = 4'h0;
        s_axi_wvalid = 1'b0; s_axi_bready = 1'b1; s_axi_araddr = 32'h0; s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b1; read_data = 32'h0;
        #2 aresetn = 1'b0;
        #2;
        check("rst_arready", 32'(s_axi_arready), 32'd0);
        check("rst_valids", 32'({s_axi_bvalid, s_axi_rvalid}), 32'd0);
        check("rst_strobes", 32'({chip_select, read, write}), 32'd0);
        check("rst_address", 32'(address), 32'd0);
        check("rst_rdata", s_axi_rdata, 32'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        check("post_rst_readies", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'h7);

        for (int i = 0; i < 9; i++) run_txn(vecs[i], i);

        // W two cycles ahead of AW: single write once both are held.
        start = strobe_log.size();
        @(negedge aclk);
        s_axi_wvalid = 1'b1; s_axi_wdata = 32'h0000_1234; s_axi_wstrb = 4'hF;
        @(posedge aclk);
        @(negedge aclk);
        s_axi_wvalid = 1'b0;
        check("wfirst_wready", 32'(s_axi_wready), 32'd0);
        check("wfirst_awready", 32'(s_axi_awready), 32'd1);
        @(negedge aclk);
        s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h08;
        @(posedge aclk);
        wait_resp(1'b1, strobe_at, resp_at, st_addr, st_wd, resp, rdat);
        @(negedge aclk);
        check("wfirst_nstrobe", 32'(strobe_log.size() - start), 32'd1);
        check("wfirst_strobe_at", 32'(strobe_at), 32'd1);
        check("wfirst_addr", 32'(st_addr), 32'h02);
        check("wfirst_wdata", st_wd, 32'h0000_1234);
        check("wfirst_b_at", 32'(resp_at), 32'd2);
        check("wfirst_bresp", 32'(resp), 32'd0);

        // Contention ordering: read first after reset, then alternates.
        do_reset();
        read_data = 32'h0000_0077;
        for (int r = 0; r < 2; r++) begin
            start = strobe_log.size();
            @(negedge aclk);
            s_axi_arvalid = 1'b1; s_axi_araddr = 32'h10;
            s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h08;
            s_axi_wvalid = 1'b1; s_axi_wdata = 32'h0000_00AB; s_axi_wstrb = 4'hF;
            @(posedge aclk);
            @(negedge aclk);
            s_axi_arvalid = 1'b0; s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
            repeat (20) @(negedge aclk);
            check($sformatf("arb%0d_count", r), 32'(strobe_log.size() - start), 32'd2);
            if (strobe_log.size() >= start + 2) begin
                check($sformatf("arb%0d_first", r), 32'(strobe_log[start]), 32'(r == 0 ? K_RD : K_WR));
                check($sformatf("arb%0d_second", r), 32'(strobe_log[start + 1]), 32'(r == 0 ? K_WR : K_RD));
            end
        end

        // Read response back-pressure.
        s_axi_rready = 1'b0;
        read_data = 32'hA5A5_0004;
        @(negedge aclk);
        s_axi_arvalid = 1'b1; s_axi_araddr = 32'h10;
        @(posedge aclk);
        @(negedge aclk);
        s_axi_arvalid = 1'b0;
        for (int i = 0; i < 10 && !s_axi_rvalid; i++) @(negedge aclk);
        check("stall_rvalid_up", 32'(s_axi_rvalid), 32'd1);
        read_data = 32'h0;
        s_axi_arvalid = 1'b1; s_axi_araddr = 32'h14;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            check($sformatf("stall%0d_rvalid", i), 32'(s_axi_rvalid), 32'd1);
            check($sformatf("stall%0d_rdata", i), s_axi_rdata, 32'hA5A5_0004);
            check($sformatf("stall%0d_arready", i), 32'(s_axi_arready), 32'd0);
        end
        s_axi_rready = 1'b1;
        @(negedge aclk);
        check("stall_hs_rvalid", 32'(s_axi_rvalid), 32'd0);
        check("stall_hs_arready", 32'(s_axi_arready), 32'd1);
        read_data = 32'h1111_0005;
        @(negedge aclk);
        check("stall_next_accepted", 32'(s_axi_arready), 32'd0);
        s_axi_arvalid = 1'b0;
        for (int i = 0; i < 10 && !s_axi_rvalid; i++) @(negedge aclk);
        check("stall_next_rdata", s_axi_rdata, 32'h1111_0005);
        @(negedge aclk);

        // Reset during RD_WAIT aborts the read with no response.
        read_data = 32'h2222_0004;
        @(negedge aclk);
        s_axi_arvalid = 1'b1; s_axi_araddr = 32'h10;
        @(posedge aclk);
        @(negedge aclk);
        s_axi_arvalid = 1'b0;
        @(negedge aclk);
        check("abort_strobe_seen", 32'(read), 32'd1);
        @(negedge aclk);
        start = strobe_log.size();
        aresetn = 1'b0;
        #1;
        check("abort_async_clear", 32'({s_axi_rvalid, read, chip_select, s_axi_arready}), 32'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        check("abort_readies", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'h7);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (s_axi_rvalid || s_axi_bvalid) seen++;
            @(negedge aclk);
        end
        check("abort_no_resp", 32'(seen), 32'd0);
        check("abort_no_strobe", 32'(strobe_log.size() - start), 32'd0);

        check("no_strobe_during_resp", 32'(overlap_cnt), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
